// File: rtl/mul_sequencer.sv
// Sequencer for ARM-style MUL/MLA/UMULL/UMLAL/SMULL/SMLAL on a shared
// external signed 32x32 multiplier with fixed pipeline latency.
module mul_sequencer #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rm,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_acc_lo,
    input  logic [31:0] req_acc_hi,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_n,
    output logic        rsp_z
);

    localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_op;
    logic [31:0]    r_rm;
    logic [31:0]    r_rs;
    logic [31:0]    r_acc_lo;
    logic [31:0]    r_acc_hi;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic [31:0]    r_lo;
    logic [31:0]    r_hi;
    logic           r_n;
    logic           r_z;

    logic           w_long;
    logic           w_acc;
    logic           w_uns;
    logic [63:0]    w_corr;
    logic [63:0]    w_p;
    logic [63:0]    w_addend;
    logic [63:0]    w_sum;

    assign w_long = (r_op == 3'd2) || (r_op == 3'd3) ||
                    (r_op == 3'd4) || (r_op == 3'd5);
    assign w_acc  = (r_op == 3'd1) || (r_op == 3'd3) || (r_op == 3'd5);
    assign w_uns  = (r_op == 3'd2) || (r_op == 3'd3);

    // Signed product reinterpreted as unsigned: add back each operand
    // shifted up wherever the other operand's top bit was negative weight.
    assign w_corr = w_uns
        ? (({r_rs, 32'd0} & {64{r_rm[31]}}) + ({r_rm, 32'd0} & {64{r_rs[31]}}))
        : 64'd0;
    assign w_p      = mul_result + w_corr;
    assign w_addend = w_acc ? {r_acc_hi, r_acc_lo} : 64'd0;
    assign w_sum    = w_p + w_addend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rm        <= '0;
            r_rs        <= '0;
            r_acc_lo    <= '0;
            r_acc_hi    <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= req_op;
                        r_rm        <= req_rm;
                        r_rs        <= req_rs;
                        r_acc_lo    <= req_acc_lo;
                        r_acc_hi    <= req_acc_hi;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= LAT_M1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_ACC;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACC: begin
                    r_lo        <= w_sum[31:0];
                    r_hi        <= w_long ? w_sum[63:32] : 32'd0;
                    r_n         <= w_long ? w_sum[63] : w_sum[31];
                    r_z         <= w_long ? (w_sum == 64'd0)
                                          : (w_sum[31:0] == 32'd0);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign mul_a     = r_rm;
    assign mul_b     = r_rs;
    assign rsp_lo    = r_lo;
    assign rsp_hi    = r_hi;
    assign rsp_n     = r_n;
    assign rsp_z     = r_z;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised and directed bench for mul_sequencer against an
// arithmetic reference model and a delayed signed multiplier model.
module tb_mul_sequencer;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_rm = '0;
    logic [31:0] req_rs = '0;
    logic [31:0] req_acc_lo = '0;
    logic [31:0] req_acc_hi = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_n;
    logic        rsp_z;

    always #5 clk = ~clk;

    mul_sequencer #(.MUL_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rm(req_rm), .req_rs(req_rs),
        .req_acc_lo(req_acc_lo), .req_acc_hi(req_acc_hi),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_n(rsp_n), .rsp_z(rsp_z)
    );

    // External signed multiplier: L-stage pipeline
    logic [63:0] r_pipe [L];
    always @(posedge clk) begin
        r_pipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign mul_result = r_pipe[L-1];

    typedef struct packed {
        logic [31:0] rm;
        logic [31:0] rs;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
        int          due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [31:0] rm, rs, alo, ahi);
        exp_t e;
        logic [63:0] p;
        logic [63:0] r;
        logic [31:0] s;
        e = '0;
        e.rm = rm;
        e.rs = rs;
        if (op >= 3'd2 && op <= 3'd5) begin
            if (op <= 3'd3) p = {32'd0, rm} * {32'd0, rs};
            else            p = {{32{rm[31]}}, rm} * {{32{rs[31]}}, rs};
            r = p + ((op == 3'd3 || op == 3'd5) ? {ahi, alo} : 64'd0);
            e.lo = r[31:0];
            e.hi = r[63:32];
            e.n  = r[63];
            e.z  = (r == 64'd0);
        end else begin
            s = rm * rs + ((op == 3'd1) ? alo : 32'd0);
            e.lo = s;
            e.hi = 32'd0;
            e.n  = s[31];
            e.z  = (s == 32'd0);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 0;
            chk("rst_valid", rsp_valid, 0);
            chk("rst_out", {rsp_hi, rsp_lo}, 0);
            chk("rst_nz", {rsp_n, rsp_z}, 0);
            chk("rst_mul", {mul_a, mul_b}, 0);
        end else begin
            chk("req_ready", req_ready, q.size() == 0);
            if (q.size() != 0)
                chk("mul_ops", {mul_a, mul_b}, {q[0].rm, q[0].rs});
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("stale_rsp", rsp_valid, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, q[0].due);
                        seen = 1;
                    end
                    chk("rsp_data", {rsp_hi, rsp_lo}, {q[0].hi, q[0].lo});
                    chk("rsp_flags", {rsp_n, rsp_z}, {q[0].n, q[0].z});
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                chk("late_rsp", rsp_valid, 1);
            end
            if (req_valid && req_ready) begin
                exp_t e;
                e = model(req_op, req_rm, req_rs, req_acc_lo, req_acc_hi);
                e.due = cyc + 1 + L + 2;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] rm, rs,
                         input logic [31:0] alo, ahi);
        int n;
        n = 0;
        req_op = op;
        req_rm = rm;
        req_rs = rs;
        req_acc_lo = alo;
        req_acc_hi = ahi;
        req_valid = 1'b1;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("accept_timeout", req_ready, 1);
        else begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic collect(input int hold, output logic [31:0] lo, hi,
                           output logic n, z, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
        lo = rsp_lo;
        hi = rsp_hi;
        n  = rsp_n;
        z  = rsp_z;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] lo, hi;
    logic        n, z;
    int          lat;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_ready", req_ready, 1);
        @(posedge clk); #1;

        issue(3'd0, 32'd7, 32'd6, 32'd0, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("mul_lo", lo, 42);
        chk("mul_hi", hi, 0);
        chk("mul_nz", {n, z}, 2'b00);
        chk("mul_lat", lat, 4);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("umull", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        chk("umull_n", n, 1);

        issue(3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        collect(1, lo, hi, n, z, lat);
        chk("smull", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("smull_nz", {n, z}, 2'b10);

        issue(3'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("smlal", {hi, lo}, 64'd0);
        chk("smlal_nz", {n, z}, 2'b01);

        issue(3'd1, 32'h0001_0000, 32'h0001_0000, 32'd5, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("mla_lo", lo, 5);
        chk("mla_hi", hi, 0);

        // Stalled response with the next request already waiting
        issue(3'd3, 32'h8000_0001, 32'h0000_0003, 32'h1234_5678, 32'h1);
        req_op = 3'd0;
        req_rm = 32'd9;
        req_rs = 32'd11;
        req_valid = 1'b1;
        collect(5, lo, hi, n, z, lat);
        chk("stall_b_pending", req_ready, 1);
        issue(3'd0, 32'd9, 32'd11, 32'd0, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("stall_b_lo", lo, 99);

        // Reset while waiting on the multiplier
        issue(3'd0, 32'd3, 32'd5, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", rsp_valid, 0);
        chk("rst_wait_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        issue(3'd0, 32'd7, 32'd6, 32'd0, 32'd0);
        collect(0, lo, hi, n, z, lat);
        chk("post_rst_lo", lo, 42);

        // Reset while a response is presented
        issue(3'd4, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_done_valid", rsp_valid, 0);
        chk("rst_done_out", {rsp_hi, rsp_lo}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd32(), rnd32(), rnd32(), rnd32());
            collect($urandom_range(0, 3), lo, hi, n, z, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
